toggle_period_meter: RTL and testbench

TOGGLE_PERIOD_METER -- requirements
Module: toggle_period_meter

---
 rtl/meter_pkg.sv | 12 +
 rtl/toggle_period_meter_if.sv | 24 ++
 rtl/edge_detect.sv | 22 ++
 rtl/toggle_period_meter.sv | 129 ++++++++++++
 tb/tb_toggle_period_meter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/meter_pkg.sv
// Shared types and defaults for the toggle period meter.
package meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

endpackage

// File: rtl/toggle_period_meter_if.sv
// Measurement record handshake bundle: producer (master) and consumer (slave) views.
interface toggle_period_meter_if #(
  parameter int unsigned CNT_W = meter_pkg::CNT_W_DEFAULT
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             sat;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output out_valid, period, high_time, sat, overflow,
    input  out_ready, clr_ovf
  );

  modport slave (
    input  out_valid, period, high_time, sat, overflow,
    output out_ready, clr_ovf
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector; the history bit resets high so a level already high
// at reset release is not reported as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures period and high time of q_in between consecutive rising edges and
// emits one record per completed period through a valid/ready output register.
module toggle_period_meter
  import meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             q_in,
  input  logic             clr_ovf,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             sat,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             rise;
  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             capture;
  logic             accept;
  logic             drop;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (q_in),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      out_valid_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      out_valid_q <= out_valid_d;
      period_q    <= period_d;
      high_q      <= high_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
    end
  end

  // en low wins over any edge and returns to IDLE from every state.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (rise) state_d = MEASURE;
        MEASURE: state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign capture = en & rise & (state_q == MEASURE);
  assign accept  = capture & (~out_valid_q | out_ready);
  assign drop    = capture & out_valid_q & ~out_ready;

  // The edge cycle itself counts as the first cycle (and first high cycle)
  // of the new period, hence the reload value of one.
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (!en || state_q == IDLE) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else if (rise) begin
      pcnt_d = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_ONE;
      if (q_in && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    period_d    = period_q;
    high_d      = high_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      period_d    = pcnt_q;
      high_d      = hcnt_q;
      sat_d       = (pcnt_q == CNT_MAX) | (hcnt_q == CNT_MAX);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign sat       = sat_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Self-checking bench for toggle_period_meter: table vectors, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_toggle_period_meter;
  import meter_pkg::*;

  localparam int unsigned W    = 8;
  localparam int          MAXV = 255;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic q_in;

  toggle_period_meter_if #(.CNT_W(W)) bus ();

  toggle_period_meter #(.CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .q_in      (q_in),
    .clr_ovf   (bus.clr_ovf),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .period    (bus.period),
    .high_time (bus.high_time),
    .sat       (bus.sat),
    .overflow  (bus.overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: rise timestamps and high-cycle sums, plus the pending record.
  int cyc;
  bit m_qprev, m_enprev, m_have_start;
  int m_tstart, m_hsum;
  bit m_valid, m_sat, m_ovf;
  int m_period, m_high;

  typedef struct {
    logic [3:0] in;   // {en, q_in, out_ready, clr_ovf}
    logic       v;
    int         p;
    int         h;
    logic       s;
    logic       o;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic void model_reset();
    cyc          = 0;
    m_qprev      = 1'b1;
    m_enprev     = 1'b0;
    m_have_start = 1'b0;
    m_tstart     = 0;
    m_hsum       = 0;
    m_valid      = 1'b0;
    m_period     = 0;
    m_high       = 0;
    m_sat        = 1'b0;
    m_ovf        = 1'b0;
  endfunction

  function automatic void model_edge();
    bit rise, cap, drp, rdy;
    int p, h;
    rise = q_in & ~m_qprev;
    rdy  = bus.out_ready;
    cap  = 1'b0;
    drp  = 1'b0;
    p    = 0;
    h    = 0;
    if (!en) begin
      m_have_start = 1'b0;
    end else if (rise && m_enprev) begin
      if (m_have_start) begin
        cap = 1'b1;
        p   = cyc - m_tstart;
        h   = m_hsum;
      end
      m_have_start = 1'b1;
      m_tstart     = cyc;
      m_hsum       = 0;
    end
    if (m_have_start) m_hsum += int'(q_in);
    if (cap) begin
      if (!m_valid || rdy) begin
        m_valid  = 1'b1;
        m_period = clip(p);
        m_high   = clip(h);
        m_sat    = (p >= MAXV) || (h >= MAXV);
      end else begin
        drp = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drp) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    m_qprev  = q_in;
    m_enprev = en;
    cyc++;
  endfunction

  task automatic step(input bit e, input bit q, input bit r, input bit c);
    en            = e;
    q_in          = q;
    bus.out_ready = r;
    bus.clr_ovf   = c;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("overflow",  int'(bus.overflow),  int'(m_ovf));
    chk("period",    int'(bus.period),    m_period);
    chk("high_time", int'(bus.high_time), m_high);
    chk("sat",       int'(bus.sat),       int'(m_sat));
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    en            = 1'b0;
    q_in          = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // Arm, run one period of hi high cycles and lo low cycles, then capture it.
  task automatic check_period(input string tag, input int hi, input int lo,
                              input int ep, input int eh, input int es);
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < hi; i++) step(1, 1, 1, 0);
    for (int i = 0; i < lo; i++) step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk({tag, "_valid"},  int'(bus.out_valid), 1);
    chk({tag, "_period"}, int'(bus.period),    ep);
    chk({tag, "_high"},   int'(bus.high_time), eh);
    chk({tag, "_sat"},    int'(bus.sat),       es);
    step(1, 0, 1, 0);
  endtask

  initial begin
    int recs, first_idx;
    bit q;
    int tprob, rpct;

    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int recs, first_idx;
    bit q;
    int tprob, rpct;

    reset         = 1'b0;
    en            = 1'b0;
    q_in          = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    #1;
    chk("rst_valid",  int'(bus.out_valid), 0);
    chk("rst_period", int'(bus.period),    0);
    chk("rst_high",   int'(bus.high_time), 0);
    chk("rst_sat",    int'(bus.sat),       0);
    chk("rst_ovf",    int'(bus.overflow),  0);
    chk("rst_state",  int'(dut.state_q),   int'(IDLE));

    // Backpressure, drop, clear, back-to-back load, en drop with a pending record.
    tv[0]  = '{4'b1000, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[1]  = '{4'b1100, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[2]  = '{4'b1100, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[3]  = '{4'b1000, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[4]  = '{4'b1100, 1'b1, 3, 2, 1'b0, 1'b0};
    tv[5]  = '{4'b1000, 1'b1, 3, 2, 1'b0, 1'b0};
    tv[6]  = '{4'b1100, 1'b1, 3, 2, 1'b0, 1'b1};
    tv[7]  = '{4'b1001, 1'b1, 3, 2, 1'b0, 1'b0};
    tv[8]  = '{4'b1000, 1'b1, 3, 2, 1'b0, 1'b0};
    tv[9]  = '{4'b1110, 1'b1, 3, 1, 1'b0, 1'b0};
    tv[10] = '{4'b1010, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[11] = '{4'b1101, 1'b1, 2, 1, 1'b0, 1'b0};
    tv[12] = '{4'b0100, 1'b1, 2, 1, 1'b0, 1'b0};
    tv[13] = '{4'b1000, 1'b1, 2, 1, 1'b0, 1'b0};
    tv[14] = '{4'b1100, 1'b1, 2, 1, 1'b0, 1'b0};
    tv[15] = '{4'b1010, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[16] = '{4'b1100, 1'b1, 2, 1, 1'b0, 1'b0};
    tv[17] = '{4'b1010, 1'b0, 0, 0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
      chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tv[i].v));
      chk($sformatf("tbl%0d_ovf", i),   int'(bus.overflow),  int'(tv[i].o));
      if (tv[i].v) begin
        chk($sformatf("tbl%0d_period", i), int'(bus.period),    tv[i].p);
        chk($sformatf("tbl%0d_high", i),   int'(bus.high_time), tv[i].h);
        chk($sformatf("tbl%0d_sat", i),    int'(bus.sat),       int'(tv[i].s));
      end
    end

    // Fastest toggle: one record every two cycles once two rises have been seen.
    do_reset();
    q = 1'b0;
    recs = 0;
    first_idx = -1;
    for (int i = 0; i < 24; i++) begin
      step(1, q, 1, 0);
      q = ~q;
      if (bus.out_valid) begin
        recs++;
        if (first_idx < 0) first_idx = i;
        chk("a_period", int'(bus.period),    2);
        chk("a_high",   int'(bus.high_time), 1);
        chk("a_sat",    int'(bus.sat),       0);
      end
    end
    chk("a_records",   recs,      11);
    chk("a_first_idx", first_idx, 3);

    // 3 high / 5 low repeating.
    do_reset();
    recs = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, (i % 8) >= 5, 1, 0);
      if (bus.out_valid) begin
        recs++;
        chk("b_period", int'(bus.period),    8);
        chk("b_high",   int'(bus.high_time), 3);
        chk("b_sat",    int'(bus.sat),       0);
      end
    end
    chk("b_records", recs, 5);

    // Saturation boundaries.
    check_period("c254",  1, 252, 254, 1,   0);
    check_period("c255",  1, 253, 255, 1,   1);
    check_period("c300",  1, 298, 255, 1,   1);
    check_period("chi",   300, 1, 255, 255, 1);

    // Drop coinciding with clr_ovf keeps overflow set.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("d_ovf_coincide", int'(bus.overflow), 1);
    step(1, 0, 0, 1);
    chk("d_ovf_cleared", int'(bus.overflow), 0);

    // Reset pulse mid-measurement with a pending record.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("e_pending", int'(bus.out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("e_rst_valid",  int'(bus.out_valid), 0);
    chk("e_rst_period", int'(bus.period),    0);
    chk("e_rst_high",   int'(bus.high_time), 0);
    chk("e_rst_ovf",    int'(bus.overflow),  0);
    chk("e_rst_sat",    int'(bus.sat),       0);
    chk("e_rst_state",  int'(dut.state_q),   int'(IDLE));
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    first_idx = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, (i % 2) == 0, 1, 0);
      if (bus.out_valid && first_idx < 0) first_idx = i;
    end
    chk("e_first_idx", first_idx, 4);

    // Randomized traffic in segments with varying toggle density and backpressure.
    do_reset();
    q = 1'b0;
    tprob = 500;
    rpct = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       tprob = 500;
          1:       tprob = 200;
          2:       tprob = 20;
          default: tprob = 3;
        endcase
        rpct = $urandom_range(20, 100);
      end
      if (i == 2000) begin
        do_reset();
        q = 1'b0;
      end
      if ($urandom_range(0, 999) < tprob) q = ~q;
      step($urandom_range(0, 99) < 97, q, $urandom_range(0, 99) < rpct,
           $urandom_range(0, 99) < 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
